// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: count-width helper and the read-path timing
// constants used by every FIFO built on a registered-read RAM.
package fifo_pkg;

  // Read address advances to the next slot in the same cycle a pop is
  // accepted, so the following word is already on the RAM output after
  // the edge.
  localparam bit FIFO_PREFETCH = 1'b1;

  // A slot written on an edge cannot be read back on that same edge:
  // the RAM returns the old contents. empty is held for one extra cycle
  // whenever the word to be presented is the one being written.
  localparam bit FIFO_EMPTY_BUBBLE = 1'b1;

  // Width needed to hold a count in the range 0..depth inclusive.
  function automatic int fifo_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port and one read port with
// a registered output. A same-address read and write on one edge returns
// the old contents.
module fifo_sdp_ram
  import fifo_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            we,
  input  logic [$clog2(C_FIFO_DEPTH)-1:0] waddr,
  input  logic [C_DATA_WIDTH-1:0]         wdata,
  input  logic [$clog2(C_FIFO_DEPTH)-1:0] raddr,
  output logic [C_DATA_WIDTH-1:0]         rdata
);

  logic [C_DATA_WIDTH-1:0] mem [0:C_FIFO_DEPTH-1];

  // Storage write and registered read; no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_fwft_prog_thresh.sv
// First-word-fall-through synchronous FIFO with runtime-programmable
// prog_full / prog_empty thresholds, single-cycle flush and one-cycle
// overflow / underflow pulses. Depth need not be a power of two.
//
// Handshake: a write is accepted on an edge where wren=1 and full=0; a pop
// is accepted on an edge where rden=1 and empty=0, and it consumes the
// word currently shown on dataout. Requests made while full/empty are
// refused (no state change) and reported on overflow/underflow instead.
module fifo_fwft_prog_thresh
  import fifo_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_FIFO_DEPTH = 16,
  parameter int C_CNT_WIDTH  = fifo_cnt_width(C_FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wren,
  input  logic [C_DATA_WIDTH-1:0] datain,
  input  logic                    rden,
  output logic [C_DATA_WIDTH-1:0] dataout,
  output logic                    empty,
  output logic                    full,
  output logic [C_CNT_WIDTH-1:0]  count,
  input  logic [C_CNT_WIDTH-1:0]  prog_full_thresh,
  input  logic [C_CNT_WIDTH-1:0]  prog_empty_thresh,
  output logic                    prog_full,
  output logic                    prog_empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int                     PTR_W    = $clog2(C_FIFO_DEPTH);
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(C_FIFO_DEPTH - 1);
  localparam logic [C_CNT_WIDTH-1:0] CNT_FULL = C_CNT_WIDTH'(C_FIFO_DEPTH);
  localparam logic [C_CNT_WIDTH-1:0] CNT_ONE  = C_CNT_WIDTH'(1);

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       rd_addr;
  logic                   wr_ok;
  logic                   rd_ok;
  logic                   ram_we;
  logic                   bubble;
  logic                   empty_nxt;
  logic [C_CNT_WIDTH-1:0] count_nxt;

  // Pointer advance with an explicit wrap so any depth works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Accept/refuse decisions, next count, prefetch address and empty bubble.
  always_comb begin
    wr_ok     = wren & ~full;
    rd_ok     = rden & ~empty;
    ram_we    = wr_ok & ~flush & ~rst;
    count_nxt = count + C_CNT_WIDTH'(wr_ok) - C_CNT_WIDTH'(rd_ok);
    rd_addr   = (rd_ok && FIFO_PREFETCH) ? ptr_inc(rd_ptr) : rd_ptr;
    // The word to present next is being written on this very edge: either
    // the FIFO is empty, or the only stored word is being popped.
    bubble    = FIFO_EMPTY_BUBBLE & wr_ok &
                ((count == '0) | (rd_ok & (count == CNT_ONE)));
    empty_nxt = (count_nxt == '0) | bubble;
  end

  // Pointers, count, status flags and error pulses; rst beats flush beats traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      prog_full  <= 1'b0;
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      prog_full  <= (prog_full_thresh == '0);
      prog_empty <= 1'b1;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count      <= count_nxt;
      empty      <= empty_nxt;
      full       <= (count_nxt == CNT_FULL);
      prog_full  <= (count_nxt >= prog_full_thresh);
      prog_empty <= (count_nxt <= prog_empty_thresh);
      overflow   <= wren & full;
      underflow  <= rden & empty;
    end
  end

  fifo_sdp_ram #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_FIFO_DEPTH (C_FIFO_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (datain),
    .raddr (rd_addr),
    .rdata (dataout)
  );

endmodule

// File: tb/tb_fifo_fwft_prog_thresh.sv
// Bench for fifo_fwft_prog_thresh: a depth-12 instance checked every cycle
// against a queue-based model plus literal expectations, and a depth-5
// instance exercised with directed literal checks across the pointer wrap.
module tb_fifo_fwft_prog_thresh;

  localparam int W   = 16;
  localparam int D   = 12;
  localparam int CW  = $clog2(D + 1);
  localparam int D5  = 5;
  localparam int CW5 = $clog2(D5 + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- main instance (depth 12) ----------------
  logic          flush = 1'b0, wren = 1'b0, rden = 1'b0;
  logic [W-1:0]  datain = '0, dataout;
  logic          empty, full, prog_full, prog_empty, overflow, underflow;
  logic [CW-1:0] count;
  logic [CW-1:0] pf_thr = CW'(10);
  logic [CW-1:0] pe_thr = CW'(1);

  fifo_fwft_prog_thresh #(.C_DATA_WIDTH(W), .C_FIFO_DEPTH(D)) u_dut (
    .clk (clk), .rst (rst), .flush (flush), .wren (wren), .datain (datain),
    .rden (rden), .dataout (dataout), .empty (empty), .full (full),
    .count (count), .prog_full_thresh (pf_thr), .prog_empty_thresh (pe_thr),
    .prog_full (prog_full), .prog_empty (prog_empty),
    .overflow (overflow), .underflow (underflow)
  );

  // ---------------- second instance (depth 5) ----------------
  logic           flush5 = 1'b0, wren5 = 1'b0, rden5 = 1'b0;
  logic [W-1:0]   datain5 = '0, dataout5;
  logic           empty5, full5, pf5, pe5, ovf5, unf5;
  logic [CW5-1:0] count5;
  logic [CW5-1:0] pf_thr5 = CW5'(4);
  logic [CW5-1:0] pe_thr5 = CW5'(1);

  fifo_fwft_prog_thresh #(.C_DATA_WIDTH(W), .C_FIFO_DEPTH(D5)) u_dut5 (
    .clk (clk), .rst (rst), .flush (flush5), .wren (wren5), .datain (datain5),
    .rden (rden5), .dataout (dataout5), .empty (empty5), .full (full5),
    .count (count5), .prog_full_thresh (pf_thr5), .prog_empty_thresh (pe_thr5),
    .prog_full (pf5), .prog_empty (pe5), .overflow (ovf5), .underflow (unf5)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the depth-12 FIFO ----------------
  logic [W-1:0] exp_q[$];
  bit m_empty = 1'b1, m_full = 1'b0, m_pf = 1'b0, m_pe = 1'b1;
  bit m_ovf = 1'b0, m_unf = 1'b0;

  // Model state advances on the same edge as the DUT, from the bench inputs only.
  always @(posedge clk) begin : model
    bit w_ok, r_ok, hold;
    int n;
    if (rst || flush) begin
      exp_q.delete();
      m_empty = 1'b1;
      m_full  = 1'b0;
      m_pf    = rst ? 1'b0 : (0 >= int'(pf_thr));
      m_pe    = 1'b1;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
    end else begin
      n     = exp_q.size();
      w_ok  = wren && !m_full;
      r_ok  = rden && !m_empty;
      m_ovf = wren && m_full;
      m_unf = rden && m_empty;
      hold  = w_ok && (n == 0 || (r_ok && n == 1));
      if (r_ok) void'(exp_q.pop_front());
      if (w_ok) exp_q.push_back(datain);
      n       = exp_q.size();
      m_empty = (n == 0) || hold;
      m_full  = (n == D);
      m_pf    = (n >= int'(pf_thr));
      m_pe    = (n <= int'(pe_thr));
    end
  end

  // Every-cycle comparison of DUT outputs with the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_count", 32'(count), 32'(exp_q.size()));
      chk("m_empty", 32'(empty), 32'(m_empty));
      chk("m_full", 32'(full), 32'(m_full));
      chk("m_prog_full", 32'(prog_full), 32'(m_pf));
      chk("m_prog_empty", 32'(prog_empty), 32'(m_pe));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_underflow", 32'(underflow), 32'(m_unf));
      if (!m_empty && exp_q.size() > 0) chk("m_dataout", 32'(dataout), 32'(exp_q[0]));
    end
  end

  // ---------------- driver tasks ----------------
  // One clock of traffic on the main instance; returns just after the next falling edge.
  task automatic cyc(input logic w, input logic r, input logic [W-1:0] d);
    wren = w; rden = r; datain = d;
    @(posedge clk);
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; flush = 1'b0;
  endtask

  task automatic cyc5(input logic w, input logic r, input logic [W-1:0] d);
    wren5 = w; rden5 = r; datain5 = d;
    @(posedge clk);
    @(negedge clk);
    wren5 = 1'b0; rden5 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [W-1:0] v5 [0:4];
    v5[0] = 16'h000A; v5[1] = 16'h000B; v5[2] = 16'h000C;
    v5[3] = 16'h000D; v5[4] = 16'h000E;

    repeat (3) @(posedge clk);
    @(negedge clk);
    // reset values
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_prog_full", 32'(prog_full), 0);
    chk("rst_prog_empty", 32'(prog_empty), 1);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst5_empty", 32'(empty5), 1);
    rst = 1'b0;
    chk_en = 1'b1;

    // depth 5: shift pointers by two so the burst crosses the wrap
    cyc5(1'b1, 1'b0, 16'h0001);
    cyc5(1'b1, 1'b0, 16'h0002);
    cyc5(1'b0, 1'b0, '0);
    cyc5(1'b0, 1'b1, '0);
    cyc5(1'b0, 1'b1, '0);
    chk("d5_drained", 32'(count5), 0);
    for (int i = 0; i < 5; i++) begin
      cyc5(1'b1, 1'b0, v5[i]);
      chk("d5_wr_count", 32'(count5), 32'(i + 1));
      if (i == 1) chk("d5_prog_empty_at2", 32'(pe5), 0);
      if (i == 2) chk("d5_prog_full_at3", 32'(pf5), 0);
      if (i == 3) chk("d5_prog_full_at4", 32'(pf5), 1);
      if (i == 3) chk("d5_full_at4", 32'(full5), 0);
    end
    chk("d5_full", 32'(full5), 1);
    chk("d5_empty_when_full", 32'(empty5), 0);
    for (int i = 0; i < 5; i++) begin
      chk("d5_order", 32'(dataout5), 32'(v5[i]));
      cyc5(1'b0, 1'b1, '0);
      if (i == 0) chk("d5_full_after_rd", 32'(full5), 0);
      if (i == 2) chk("d5_prog_empty_at2r", 32'(pe5), 0);
      if (i == 3) chk("d5_prog_empty_at1", 32'(pe5), 1);
    end
    chk("d5_end_empty", 32'(empty5), 1);
    chk("d5_end_prog_empty", 32'(pe5), 1);
    chk("d5_end_count", 32'(count5), 0);

    // single write latency and the count==1 pass-through bubble
    cyc(1'b1, 1'b0, 16'h0055);
    chk("lat_empty_e", 32'(empty), 1);
    chk("lat_count_e", 32'(count), 1);
    cyc(1'b0, 1'b0, '0);
    chk("lat_empty_e1", 32'(empty), 0);
    chk("lat_data_e1", 32'(dataout), 32'h55);
    cyc(1'b1, 1'b1, 16'h0066);
    chk("bub_empty", 32'(empty), 1);
    chk("bub_count", 32'(count), 1);
    cyc(1'b0, 1'b0, '0);
    chk("bub_data", 32'(dataout), 32'h66);
    chk("bub_empty_after", 32'(empty), 0);
    cyc(1'b0, 1'b1, '0);
    chk("pop_last_empty", 32'(empty), 1);

    // underflow on empty
    cyc(1'b0, 1'b1, '0);
    chk("unf_pulse", 32'(underflow), 1);
    chk("unf_count", 32'(count), 0);
    cyc(1'b0, 1'b0, '0);
    chk("unf_clear", 32'(underflow), 0);

    // threshold retune with no traffic at count 6
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 16'h0010 + 16'(i));
    chk("thr_count6", 32'(count), 6);
    chk("thr_pf_before", 32'(prog_full), 0);
    pf_thr = CW'(6);
    cyc(1'b0, 1'b0, '0);
    chk("thr_pf_lowered", 32'(prog_full), 1);
    pf_thr = CW'(10);
    cyc(1'b0, 1'b0, '0);
    chk("thr_pf_raised", 32'(prog_full), 0);

    // flush at count 7 together with wren & rden
    cyc(1'b1, 1'b0, 16'h0016);
    chk("fl_count7", 32'(count), 7);
    flush = 1'b1;
    cyc(1'b1, 1'b1, 16'h00FF);
    chk("fl_count", 32'(count), 0);
    chk("fl_empty", 32'(empty), 1);
    chk("fl_prog_empty", 32'(prog_empty), 1);
    chk("fl_no_ovf", 32'(overflow), 0);
    chk("fl_no_unf", 32'(underflow), 0);
    cyc(1'b1, 1'b0, 16'h0077);
    chk("fl_wr_bubble", 32'(empty), 1);
    cyc(1'b0, 1'b0, '0);
    chk("fl_wr_data", 32'(dataout), 32'h77);
    cyc(1'b0, 1'b1, '0);

    // full: simultaneous wren & rden drops the write and pulses overflow
    for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 16'h0020 + 16'(i));
    chk("full_set", 32'(full), 1);
    cyc(1'b1, 1'b1, 16'h00EE);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_count", 32'(count), D - 1);
    chk("ovf_full_clear", 32'(full), 0);
    chk("ovf_head", 32'(dataout), 32'h21);
    cyc(1'b0, 1'b0, '0);
    chk("ovf_clear", 32'(overflow), 0);
    for (int i = 1; i < D; i++) begin
      chk("ovf_order", 32'(dataout), 32'h20 + 32'(i));
      cyc(1'b0, 1'b1, '0);
    end
    chk("ovf_drained", 32'(empty), 1);

    // random traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 10000; i++) begin
      bit heavy;
      heavy = ((i / 300) % 2) == 0;
      if ($urandom_range(0, 299) == 0) flush = 1'b1;
      if ($urandom_range(0, 49) == 0) pf_thr = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) pe_thr = CW'($urandom_range(0, 15));
      cyc(($urandom_range(0, 99) < (heavy ? 70 : 30)),
          ($urandom_range(0, 99) < (heavy ? 30 : 70)),
          W'($urandom_range(0, 65535)));
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
